// File: rtl/spi_uvc_pkg.sv
// Shared types and helpers for the SPI master engine.
package spi_uvc_pkg;

  localparam int SPI_DEFAULT_DATA_W = 8;

  typedef struct packed {
    logic cpol;
    logic cpha;
    logic lsb_first;
  } spi_mode_t;

  typedef enum logic [2:0] {
    IDLE,
    LEAD,
    SHIFT,
    TRAIL,
    DONE
  } spi_state_e;

  // Chip-select index width; a single CS line still needs a 1-bit select.
  function automatic int spi_cs_w(input int n_cs);
    return (n_cs > 1) ? $clog2(n_cs) : 1;
  endfunction

endpackage

// File: rtl/spi_uvc_if.sv
// Word-level front end plus SPI pin bundle of the master engine.
interface spi_uvc_if
  import spi_uvc_pkg::*;
#(
  parameter int DATA_W = SPI_DEFAULT_DATA_W,
  parameter int N_CS   = 4,
  parameter int DIV_W  = 8
);
  localparam int CS_W = spi_cs_w(N_CS);

  logic              cpol_i;
  logic              cpha_i;
  logic              lsb_first_i;
  logic [DIV_W-1:0]  clk_div_i;
  logic [CS_W-1:0]   cs_sel_i;
  logic              tx_valid_i;
  logic              tx_ready_o;
  logic [DATA_W-1:0] tx_data_i;
  logic              rx_valid_o;
  logic [DATA_W-1:0] rx_data_o;
  logic              busy_o;
  logic              sclk_o;
  logic              mosi_o;
  logic              miso_i;
  logic [N_CS-1:0]   cs_n_o;

  modport master (
    input  cpol_i, cpha_i, lsb_first_i, clk_div_i, cs_sel_i,
    input  tx_valid_i, tx_data_i, miso_i,
    output tx_ready_o, rx_valid_o, rx_data_o, busy_o, sclk_o, mosi_o, cs_n_o
  );

  modport slave (
    output cpol_i, cpha_i, lsb_first_i, clk_div_i, cs_sel_i,
    output tx_valid_i, tx_data_i, miso_i,
    input  tx_ready_o, rx_valid_o, rx_data_o, busy_o, sclk_o, mosi_o, cs_n_o
  );

endinterface

// File: rtl/spi_uvc_clkgen.sv
// Half-period counter: strobes on the last cycle of every H-cycle period
// and toggles the SCLK level on strobes where toggling is enabled.
module spi_uvc_clkgen #(
  parameter int DIV_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             i_en,
  input  logic             i_tog_en,
  input  logic             i_cpol,
  input  logic [DIV_W-1:0] i_div,
  output logic             o_strobe,
  output logic             o_sclk
);

  logic [DIV_W-1:0] r_cnt;
  logic             r_sclk;

  assign o_strobe = i_en && (r_cnt == i_div);
  assign o_sclk   = r_sclk;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt  <= '0;
      r_sclk <= 1'b0;
    end else if (!i_en) begin
      // Parked: restart the period and hold SCLK at the idle level.
      r_cnt  <= '0;
      r_sclk <= i_cpol;
    end else if (o_strobe) begin
      r_cnt <= '0;
      if (i_tog_en) r_sclk <= ~r_sclk;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spi_uvc_master.sv
// SPI master engine: one DATA_W-bit word per transaction, all CPOL/CPHA
// modes, MSB/LSB-first, programmable SCLK divider, one-hot chip selects.
module spi_uvc_master
  import spi_uvc_pkg::*;
#(
  parameter int DATA_W = SPI_DEFAULT_DATA_W,
  parameter int N_CS   = 4,
  parameter int DIV_W  = 8
) (
  input logic       clk_i,
  input logic       rst_i,
  spi_uvc_if.master bus
);

  localparam int CS_W  = spi_cs_w(N_CS);
  localparam int EDGES = 2 * DATA_W;
  localparam int CNT_W = $clog2(EDGES + 2);

  spi_state_e        r_state, w_state_nxt;
  spi_mode_t         r_mode;
  logic [DIV_W-1:0]  r_div;
  logic [DATA_W-1:0] r_tx, r_rx, r_rx_data;
  logic              r_mosi;
  logic [N_CS-1:0]   r_cs_n;
  logic [CNT_W-1:0]  r_edge;

  logic w_accept, w_en, w_busy, w_strobe, w_sclk, w_cpol;
  logic w_tog_en, w_sample, w_drive, w_last;

  function automatic logic first_bit(input logic [DATA_W-1:0] d, input logic lsb);
    return lsb ? d[0] : d[DATA_W-1];
  endfunction

  function automatic logic [DATA_W-1:0] shift_tx(input logic [DATA_W-1:0] d, input logic lsb);
    return lsb ? (d >> 1) : (d << 1);
  endfunction

  function automatic logic [DATA_W-1:0] shift_rx(input logic [DATA_W-1:0] d, input logic b,
                                                 input logic lsb);
    return lsb ? {b, d[DATA_W-1:1]} : {d[DATA_W-2:0], b};
  endfunction

  // Out-of-range selects leave every line deasserted.
  function automatic logic [N_CS-1:0] cs_decode(input logic [CS_W-1:0] sel);
    logic [N_CS-1:0] v;
    v = '1;
    for (int i = 0; i < N_CS; i++)
      if (sel == CS_W'(i)) v[i] = 1'b0;
    return v;
  endfunction

  spi_uvc_clkgen #(.DIV_W(DIV_W)) u_clkgen (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .i_en     (w_en),
    .i_tog_en (w_tog_en),
    .i_cpol   (w_cpol),
    .i_div    (r_div),
    .o_strobe (w_strobe),
    .o_sclk   (w_sclk)
  );

  assign w_cpol   = (r_state == IDLE) ? bus.cpol_i : r_mode.cpol;
  // Strobes 0..EDGES-1 are real SCLK edges; the two after that end SHIFT and TRAIL.
  assign w_tog_en = (r_edge < CNT_W'(EDGES));
  assign w_sample = w_strobe && w_tog_en && (r_mode.cpha ? r_edge[0] : ~r_edge[0]);
  assign w_drive  = w_strobe && w_tog_en &&
                    (r_mode.cpha ? ~r_edge[0] : (r_edge[0] && (r_edge != CNT_W'(EDGES - 1))));
  assign w_last   = (r_state == TRAIL) && w_strobe;

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_en        = 1'b0;
    w_busy      = 1'b1;
    unique case (r_state)
      IDLE: begin
        w_busy   = 1'b0;
        w_accept = bus.tx_valid_i;
        if (bus.tx_valid_i) w_state_nxt = LEAD;
      end
      LEAD: begin
        w_en = 1'b1;
        if (w_strobe) w_state_nxt = SHIFT;
      end
      SHIFT: begin
        w_en = 1'b1;
        if (w_strobe && (r_edge == CNT_W'(EDGES))) w_state_nxt = TRAIL;
      end
      TRAIL: begin
        w_en = 1'b1;
        if (w_strobe) w_state_nxt = DONE;
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_edge    <= '0;
      r_cs_n    <= '1;
      r_mosi    <= 1'b0;
      r_rx_data <= '0;
    end else begin
      if (r_state == IDLE) r_edge <= '0;
      else if (w_strobe)   r_edge <= r_edge + 1'b1;

      if (w_accept)    r_cs_n <= cs_decode(bus.cs_sel_i);
      else if (w_last) r_cs_n <= '1;

      // With CPHA=0 the first bit must be on the wire before the first edge.
      if (w_accept)              r_mosi <= bus.cpha_i ? 1'b0
                                           : first_bit(bus.tx_data_i, bus.lsb_first_i);
      else if (w_drive)          r_mosi <= first_bit(r_tx, r_mode.lsb_first);
      else if (r_state == DONE)  r_mosi <= 1'b0;

      if (w_last) r_rx_data <= r_rx;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_accept) begin
      r_mode.cpol      <= bus.cpol_i;
      r_mode.cpha      <= bus.cpha_i;
      r_mode.lsb_first <= bus.lsb_first_i;
      r_div            <= bus.clk_div_i;
      r_tx             <= bus.cpha_i ? bus.tx_data_i : shift_tx(bus.tx_data_i, bus.lsb_first_i);
    end else if (w_drive) begin
      r_tx <= shift_tx(r_tx, r_mode.lsb_first);
    end
    if (w_sample) r_rx <= shift_rx(r_rx, bus.miso_i, r_mode.lsb_first);
  end

  assign bus.tx_ready_o = ~w_busy;
  assign bus.busy_o     = w_busy;
  assign bus.rx_valid_o = (r_state == DONE);
  assign bus.rx_data_o  = r_rx_data;
  assign bus.mosi_o     = r_mosi;
  assign bus.cs_n_o     = r_cs_n;
  assign bus.sclk_o     = (r_state == IDLE) ? bus.cpol_i : w_sclk;

endmodule

// File: tb/tb_spi_uvc_master.sv
// Scoreboard bench for spi_uvc_master with a loopback / mode-aware SPI slave.
module tb_spi_uvc_master;
  import spi_uvc_pkg::*;

  localparam int DW  = 8;
  localparam int NCS = 3;
  localparam int DVW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_uvc_if #(.DATA_W(DW), .N_CS(NCS), .DIV_W(DVW)) bus ();

  spi_uvc_master #(.DATA_W(DW), .N_CS(NCS), .DIV_W(DVW)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  typedef struct {
    logic [7:0]     rx;
    logic [7:0]     mosi;
    bit             chk_mosi;
    int             done_cyc;
    logic [NCS-1:0] cs_mask;
    int             cs_cnt;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   n_rx     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Slave: loopback, or a mode-aware shift register presenting s_word.
  bit         loopback = 1'b1;
  logic       s_miso   = 1'b0;
  logic [7:0] s_word   = '0;
  logic [7:0] s_sh     = '0;
  logic [7:0] s_rx     = '0;
  int         s_edge   = 0;
  logic       s_cs_prev   = 1'b0;
  logic       s_sclk_prev = 1'b0;

  assign bus.miso_i = loopback ? bus.mosi_o : s_miso;

  task drive_bit;
    s_miso = bus.lsb_first_i ? s_sh[0] : s_sh[7];
    s_sh   = bus.lsb_first_i ? (s_sh >> 1) : (s_sh << 1);
  endtask

  initial forever begin
    @(negedge clk);
    if ((bus.cs_n_o != '1) && !s_cs_prev) begin
      s_edge = 0;
      s_sh   = s_word;
      s_rx   = '0;
      if (!bus.cpha_i) drive_bit();
    end else if ((bus.cs_n_o != '1) && (bus.sclk_o != s_sclk_prev)) begin
      s_edge++;
      if ((bus.cpha_i == 1'b0) == (s_edge % 2 == 1))
        s_rx = bus.lsb_first_i ? {bus.mosi_o, s_rx[7:1]} : {s_rx[6:0], bus.mosi_o};
      if (bus.cpha_i ? (s_edge % 2 == 1) : ((s_edge % 2 == 0) && (s_edge != 2 * DW)))
        drive_bit();
    end
    s_cs_prev   = (bus.cs_n_o != '1);
    s_sclk_prev = bus.sclk_o;
  end

  // Monitor: pops the scoreboard on every rx pulse.
  int             m_cs_cnt = 0;
  logic [NCS-1:0] m_cs_or  = '0;
  exp_t           m_e;

  initial forever begin
    @(negedge clk);
    if (rst) begin
      m_cs_cnt = 0;
      m_cs_or  = '0;
    end else begin
      if (bus.cs_n_o != '1) begin
        m_cs_cnt++;
        m_cs_or |= ~bus.cs_n_o;
      end
      if (bus.rx_valid_o) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_rx_valid", 32'(bus.rx_valid_o), 32'd0);
        end else begin
          m_e = sb_q.pop_front();
          chk("rx_data", 32'(bus.rx_data_o), 32'(m_e.rx));
          chk("rx_cycle", 32'(cyc), 32'(m_e.done_cyc));
          chk("cs_low_cycles", 32'(m_cs_cnt), 32'(m_e.cs_cnt));
          chk("cs_lines", 32'(m_cs_or), 32'(m_e.cs_mask));
          if (m_e.chk_mosi) chk("mosi_word", 32'(s_rx), 32'(m_e.mosi));
          n_rx++;
        end
        m_cs_cnt = 0;
        m_cs_or  = '0;
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic start_tx(input logic cpol, input logic cpha, input logic lsb,
                          input logic [7:0] div, input logic [1:0] sel,
                          input logic [7:0] data, input bit hold, output int t0);
    bus.cpol_i      = cpol;
    bus.cpha_i      = cpha;
    bus.lsb_first_i = lsb;
    bus.clk_div_i   = div;
    bus.cs_sel_i    = sel;
    bus.tx_data_i   = data;
    bus.tx_valid_i  = 1'b1;
    t0 = -1;
    for (int i = 0; i < 400; i++) begin
      if (bus.tx_ready_o) begin
        t0 = cyc;
        break;
      end
      @(negedge clk);
    end
    if (t0 < 0) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout actual=no_ready required=ready_within_400");
    end
    @(negedge clk);
    if (!hold) bus.tx_valid_i = 1'b0;
  endtask

  // Transaction length: LEAD H + SHIFT 16H + TRAIL H = 18H cycles, DONE after.
  task automatic push_exp(input int t0, input int h, input logic [7:0] rx,
                          input logic [7:0] mosi, input bit chkm, input logic [NCS-1:0] mask);
    exp_t e;
    e.rx       = rx;
    e.mosi     = mosi;
    e.chk_mosi = chkm;
    e.done_cyc = t0 + h * 18 + 1;
    e.cs_mask  = mask;
    e.cs_cnt   = (mask == '0) ? 0 : h * 18;
    sb_q.push_back(e);
  endtask

  task automatic wait_idle(input int bound);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      if ((sb_q.size() == 0) && bus.tx_ready_o) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout actual=pending=%0d required=pending=0", sb_q.size());
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  int t0, t0a, t0b, rx_before;

  initial begin
    bus.cpol_i = 1'b0; bus.cpha_i = 1'b0; bus.lsb_first_i = 1'b0;
    bus.clk_div_i = '0; bus.cs_sel_i = '0; bus.tx_valid_i = 1'b0; bus.tx_data_i = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    bus.cpol_i = 1'b1;
    #1;
    chk("rst_tx_ready", 32'(bus.tx_ready_o), 32'd1);
    chk("rst_busy", 32'(bus.busy_o), 32'd0);
    chk("rst_rx_valid", 32'(bus.rx_valid_o), 32'd0);
    chk("rst_rx_data", 32'(bus.rx_data_o), 32'd0);
    chk("rst_mosi", 32'(bus.mosi_o), 32'd0);
    chk("rst_cs_n", 32'(bus.cs_n_o), 32'b111);
    chk("rst_sclk_cpol1", 32'(bus.sclk_o), 32'd1);
    bus.cpol_i = 1'b0;
    #1;
    chk("rst_sclk_cpol0", 32'(bus.sclk_o), 32'd0);
    @(negedge clk);

    // Mode 0, H=1, loopback 0xA5
    loopback = 1'b1;
    start_tx(1'b0, 1'b0, 1'b0, 8'd0, 2'd0, 8'hA5, 1'b0, t0);
    push_exp(t0, 1, 8'hA5, 8'hA5, 1'b1, 3'b001);
    wait_idle(200);

    // Mode 3, H=4, slave returns 0x3C, master sends 0xC3
    loopback = 1'b0;
    s_word = 8'h3C;
    bus.cpol_i = 1'b1;
    bus.cpha_i = 1'b1;
    @(negedge clk);
    chk("m3_sclk_idle_before", 32'(bus.sclk_o), 32'd1);
    start_tx(1'b1, 1'b1, 1'b0, 8'd3, 2'd0, 8'hC3, 1'b0, t0);
    chk("m3_sclk_lead", 32'(bus.sclk_o), 32'd1);
    push_exp(t0, 4, 8'h3C, 8'hC3, 1'b1, 3'b001);
    wait_idle(400);
    chk("m3_sclk_idle_after", 32'(bus.sclk_o), 32'd1);

    // Mode 1, LSB-first, H=2, loopback 0x01
    loopback = 1'b1;
    start_tx(1'b0, 1'b1, 1'b1, 8'd1, 2'd1, 8'h01, 1'b0, t0);
    push_exp(t0, 2, 8'h01, 8'h01, 1'b1, 3'b010);
    repeat (2) @(negedge clk);
    chk("m1_edge1_sclk", 32'(bus.sclk_o), 32'd1);
    chk("m1_edge1_mosi", 32'(bus.mosi_o), 32'd1);
    wait_idle(200);

    // Back-to-back on cs_sel=2 with tx_valid held
    rx_before = n_rx;
    start_tx(1'b0, 1'b0, 1'b0, 8'd0, 2'd2, 8'h5A, 1'b1, t0a);
    push_exp(t0a, 1, 8'h5A, 8'h5A, 1'b1, 3'b100);
    start_tx(1'b0, 1'b0, 1'b0, 8'd0, 2'd2, 8'h96, 1'b0, t0b);
    push_exp(t0b, 1, 8'h96, 8'h96, 1'b1, 3'b100);
    chk("b2b_accept_cycle", 32'(t0b), 32'(t0a + 20));
    wait_idle(200);
    chk("b2b_rx_pulses", 32'(n_rx - rx_before), 32'd2);

    // Reset at SCLK edge 5 (mode 2, H=2)
    rx_before = n_rx;
    start_tx(1'b1, 1'b0, 1'b0, 8'd1, 2'd1, 8'hFF, 1'b0, t0);
    repeat (10) @(negedge clk);
    chk("rst5_sclk_at_edge5", 32'(bus.sclk_o), 32'd0);
    chk("rst5_busy_at_edge5", 32'(bus.busy_o), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst5_cs_n", 32'(bus.cs_n_o), 32'b111);
    chk("rst5_sclk", 32'(bus.sclk_o), 32'd1);
    chk("rst5_tx_ready", 32'(bus.tx_ready_o), 32'd1);
    chk("rst5_mosi", 32'(bus.mosi_o), 32'd0);
    chk("rst5_rx_data", 32'(bus.rx_data_o), 32'd0);
    rst = 1'b0;
    repeat (60) @(negedge clk);
    chk("rst5_no_rx_pulse", 32'(n_rx - rx_before), 32'd0);

    // Out-of-range chip select
    start_tx(1'b0, 1'b0, 1'b0, 8'd0, 2'd3, 8'h3C, 1'b0, t0);
    push_exp(t0, 1, 8'h3C, 8'h00, 1'b0, 3'b000);
    wait_idle(200);

    chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
